// File: rtl/npu_issue_ctrl.sv
// rtl/npu_issue_ctrl.sv - in-order command issue stage; perf counters built when NPU_ISSUE_PERF_EN is defined
module npu_issue_ctrl #(
    parameter int NUM_ENGINES = 6,
    parameter int CMD_W       = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_kind,
    input  logic [2:0]             in_engine_id,
    input  logic [CMD_W-1:0]       in_payload,
    input  logic [NUM_ENGINES-1:0] can_issue,
    input  logic                   all_idle,
    output logic                   issue_valid,
    output logic [2:0]             issue_engine_id,
    output logic [NUM_ENGINES-1:0] eng_cmd_valid,
    input  logic [NUM_ENGINES-1:0] eng_cmd_ready,
    output logic [CMD_W-1:0]       eng_cmd_payload,
    output logic                   running,
    output logic                   halt_pulse,
    output logic                   illegal_err,
    output logic [31:0]            issue_count,
    output logic [31:0]            stall_count
);

    typedef enum logic [2:0] {
        S_STOP,
        S_IDLE,
        S_DISPATCH,
        S_BARRIER,
        S_DRAIN
    } state_t;

    localparam logic [3:0] ENG_LIMIT = 4'(NUM_ENGINES);

    state_t           state;
    logic [2:0]       cmd_id;
    logic [CMD_W-1:0] cmd_payload;
    logic             fire;
    logic             accept;
    logic             id_legal;
    state_t           accept_next;
    logic             accept_illegal;

    // can_issue/eng_cmd_ready come from registered sources, so no path from in_valid reaches these.
    assign fire     = (state == S_DISPATCH) && can_issue[cmd_id] && eng_cmd_ready[cmd_id];
    assign in_ready = (state == S_IDLE) || fire;
    assign accept   = in_valid && in_ready;
    assign id_legal = {1'b0, in_engine_id} < ENG_LIMIT;

    always_comb begin
        accept_next    = S_IDLE;
        accept_illegal = 1'b0;
        case (in_kind)
            2'd0: begin
                if (id_legal) accept_next = S_DISPATCH;
                else          accept_illegal = 1'b1;
            end
            2'd1:    accept_next = S_BARRIER;
            2'd2:    accept_next = S_DRAIN;
            default: accept_illegal = 1'b1;
        endcase
    end

    always_comb begin
        eng_cmd_valid = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            eng_cmd_valid[i] = (state == S_DISPATCH) && (cmd_id == 3'(i)) && can_issue[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_STOP;
            cmd_id      <= '0;
            cmd_payload <= '0;
            halt_pulse  <= 1'b0;
            illegal_err <= 1'b0;
        end else begin
            halt_pulse <= 1'b0;
            case (state)
                S_STOP: begin
                    if (start) state <= S_IDLE;
                end
                S_IDLE, S_DISPATCH: begin
                    if (accept) begin
                        state <= accept_next;
                        if (accept_next == S_DISPATCH) begin
                            cmd_id      <= in_engine_id;
                            cmd_payload <= in_payload;
                        end
                        if (accept_illegal) illegal_err <= 1'b1;
                    end else if (fire) begin
                        state <= S_IDLE;
                    end
                end
                S_BARRIER: begin
                    if (all_idle) state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (all_idle) begin
                        state      <= S_STOP;
                        halt_pulse <= 1'b1;
                    end
                end
                default: state <= S_STOP;
            endcase
        end
    end

    assign issue_valid     = fire;
    assign issue_engine_id = cmd_id;
    assign eng_cmd_payload = cmd_payload;
    assign running         = (state != S_STOP);

`ifdef NPU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (fire) issue_count <= issue_count + 32'd1;
            if (((state == S_DISPATCH) && !fire) || ((state == S_BARRIER) && !all_idle))
                stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign issue_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_npu_issue_ctrl.sv
// tb/tb_npu_issue_ctrl.sv - scoreboard bench for npu_issue_ctrl with a behavioural engine scoreboard
module tb_npu_issue_ctrl;

    localparam int NE = 6;
    localparam int CW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_kind = '0;
    logic [2:0]    in_engine_id = '0;
    logic [CW-1:0] in_payload = '0;
    logic [NE-1:0] can_issue;
    logic          all_idle;
    logic          issue_valid;
    logic [2:0]    issue_engine_id;
    logic [NE-1:0] eng_cmd_valid;
    logic [NE-1:0] eng_cmd_ready;
    logic [CW-1:0] eng_cmd_payload;
    logic          running;
    logic          halt_pulse;
    logic          illegal_err;
    logic [31:0]   issue_count;
    logic [31:0]   stall_count;

    npu_issue_ctrl #(.NUM_ENGINES(NE), .CMD_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_engine_id(in_engine_id), .in_payload(in_payload),
        .can_issue(can_issue), .all_idle(all_idle),
        .issue_valid(issue_valid), .issue_engine_id(issue_engine_id),
        .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
        .eng_cmd_payload(eng_cmd_payload), .running(running),
        .halt_pulse(halt_pulse), .illegal_err(illegal_err),
        .issue_count(issue_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int halt_cnt = 0;
    int halt_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine scoreboard: busy is set on the edge that issues and cleared dur cycles later.
    logic [NE-1:0] busy = '0;
    logic [NE-1:0] rdy = '1;
    int left[NE];
    int dur[NE];
    assign can_issue     = ~busy;
    assign all_idle      = (busy == '0);
    assign eng_cmd_ready = rdy;

    always @(posedge clk) begin
        for (int i = 0; i < NE; i++) begin
            if (issue_valid && issue_engine_id == 3'(i)) begin
                busy[i] <= 1'b1;
                left[i] <= dur[i];
            end else if (busy[i]) begin
                left[i] <= left[i] - 1;
                if (left[i] == 1) busy[i] <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [2:0]    id;
        logic [CW-1:0] pl;
        int            cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pc(input int v);
`ifdef NPU_ISSUE_PERF_EN
        return 32'(v);
`else
        return 32'(0 * v);
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && issue_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got engine %0d expected no issue (cycle %0d)", issue_engine_id, cyc);
            end else begin
                exp_t e;
                logic [NE-1:0] oh;
                e  = q.pop_front();
                oh = NE'(1) << e.id;
                chk("issue_engine_id", 64'(issue_engine_id), 64'(e.id));
                chk("eng_cmd_valid", 64'(eng_cmd_valid), 64'(oh));
                chk("eng_cmd_payload", eng_cmd_payload, e.pl);
                chk("fire_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (rst_n && halt_pulse) begin
            halt_cnt++;
            halt_cyc = cyc;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the command.
    task automatic send(input logic [1:0] k, input logic [2:0] id, input logic [CW-1:0] pl,
                        input int lat, output int acc);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_kind = k;
        in_engine_id = id;
        in_payload = pl;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else if (++n > 200) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                done = 1;
            end
        end
        acc = cyc;
        if (lat > 0) q.push_back('{id: id, pl: pl, cyc: acc + lat});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(all_idle && in_ready && q.size() == 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_eng_cmd_valid", 64'(eng_cmd_valid), 64'd0);
        chk("rst_payload", eng_cmd_payload, 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_halt_pulse", 64'(halt_pulse), 64'd0);
        chk("rst_illegal_err", 64'(illegal_err), 64'd0);
        chk("rst_issue_count", 64'(issue_count), 64'd0);
        chk("rst_stall_count", 64'(stall_count), 64'd0);
        chk("rst_issue_engine_id", 64'(issue_engine_id), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int a, b, c, f;
        for (int i = 0; i < NE; i++) dur[i] = 3;

        repeat (2) @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // STOP ignores commands
        in_valid = 1'b1;
        @(negedge clk);
        chk("stop_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("start_running", 64'(running), 64'd1);
        chk("start_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // single dispatch
        send(2'd0, 3'd2, 64'hA5, 1, a);
        wait_idle();
        chk("t1_issue_count", 64'(issue_count), 64'(pc(1)));

        // same engine back-to-back, engine busy for 10 cycles
        dur[1] = 10;
        send(2'd0, 3'd1, 64'h1111, 1, a);
        send(2'd0, 3'd1, 64'h2222, 11, b);
        chk("t2_second_accept", 64'(b), 64'(a + 1));
        wait_idle();
        chk("t2_stall_count", 64'(stall_count), 64'(pc(10)));

        // distinct engines in consecutive cycles
        send(2'd0, 3'd0, 64'hDEAD_BEEF_0000_0001, 1, a);
        send(2'd0, 3'd3, 64'h0123_4567_89AB_CDEF, 1, b);
        chk("t3_consecutive", 64'(b), 64'(a + 1));
        wait_idle();
        chk("t3_issue_count", 64'(issue_count), 64'(pc(5)));

        // barrier right after an issue
        dur[4] = 5;
        send(2'd0, 3'd4, 64'h44, 1, a);
        send(2'd1, 3'd0, 64'h0, 0, b);
        send(2'd0, 3'd0, 64'h55, 1, c);
        chk("t4_barrier_release", 64'(c), 64'(b + 7));
        wait_idle();
        chk("t4_stall_count", 64'(stall_count), 64'(pc(15)));
        chk("t4_issue_count", 64'(issue_count), 64'(pc(7)));

        // illegal engine id and reserved kind
        send(2'd0, 3'd7, 64'h77, 0, a);
        send(2'd3, 3'd0, 64'h33, 0, b);
        @(negedge clk);
        chk("t5_illegal_err", 64'(illegal_err), 64'd1);
        chk("t5_still_idle", 64'(in_ready), 64'd1);
        chk("t5_issue_count", 64'(issue_count), 64'(pc(7)));
        @(posedge clk);
        #1;

        // END with engine 5 busy for 8 cycles
        dur[5] = 8;
        send(2'd0, 3'd5, 64'h5555, 1, a);
        send(2'd2, 3'd0, 64'h0, 0, f);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cyc == f + 9)  chk("t6_running_before", 64'(running), 64'd1);
            if (cyc == f + 10) chk("t6_running_after", 64'(running), 64'd0);
        end
        chk("t6_halt_count", 64'(halt_cnt), 64'd1);
        chk("t6_halt_cycle", 64'(halt_cyc), 64'(f + 10));
        chk("t6_illegal_sticky", 64'(illegal_err), 64'd1);
        chk("t6_issue_count", 64'(issue_count), 64'(pc(8)));
        chk("t6_stall_count", 64'(stall_count), 64'(pc(15)));
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        chk("t6_restart_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // reset while a command is held in DISPATCH
        rdy[2] = 1'b0;
        send(2'd0, 3'd2, 64'hCAFE, 0, a);
        @(negedge clk);
        chk("t7_held_valid", 64'(eng_cmd_valid), 64'h04);
        chk("t7_held_payload", eng_cmd_payload, 64'hCAFE);
        rst_n = 1'b0;
        #1;
        check_reset();
        rdy[2] = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/npu_issue_ctrl.md
# npu_issue_ctrl

In-order command issue stage between instruction decode and the engine scoreboard. It accepts decoded commands one at a time and holds each one until the target engine is free and ready. It then dispatches the command to that engine and sends the issue notification to the scoreboard. It also implements BARRIER (wait for all engines idle) and END (drain, then stop).

## Interface
- NUM_ENGINES, 6, number of compute engines; legal ids 0..NUM_ENGINES-1, NUM_ENGINES ≤ 8
- CMD_W, 64, engine command payload width

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; leaves STOP
- in_valid  in  1  decoded command valid
- in_ready  out  1  command accepted when in_valid & in_ready
- in_kind  in  2  0=ENGINE, 1=BARRIER, 2=END, 3=reserved
- in_engine_id  in  3  target engine (ENGINE only)
- in_payload  in  CMD_W  engine command (ENGINE only)
- can_issue  in  NUM_ENGINES  per-engine free, from scoreboard (registered there)
- all_idle  in  1  all engines free, from scoreboard
- issue_valid  out  1  issue notification to scoreboard
- issue_engine_id  out  3  engine being issued
- eng_cmd_valid  out  NUM_ENGINES  one-hot command valid per engine
- eng_cmd_ready  in  NUM_ENGINES  per-engine command ready
- eng_cmd_payload  out  CMD_W  shared payload bus
- running  out  1  not in STOP
- halt_pulse  out  1  one cycle on DRAIN→STOP
- illegal_err  out  1  sticky; illegal kind or engine id seen
- issue_count  out  32  commands dispatched (perf)
- stall_count  out  32  cycles spent in DISPATCH/BARRIER without firing (perf)

## Operation
- States: STOP (reset), IDLE, DISPATCH, BARRIER, DRAIN.
- STOP: in_ready=0. start→IDLE. start is ignored in every other state.
- IDLE: in_ready=1. On accept the command is registered (kind, id, payload):
  - ENGINE with legal id→DISPATCH.
  - BARRIER→BARRIER.
  - END→DRAIN.
  - Kind 3 or id ≥ NUM_ENGINES: command dropped, illegal_err set, stay IDLE.
- DISPATCH:
  - eng_cmd_valid[id] = can_issue[id]; all other bits are 0.
  - fire = can_issue[id] & eng_cmd_ready[id].
  - On fire: issue_valid=1 and issue_engine_id=id in the same cycle; issue_count increments.
  - in_ready = fire, so a new command is accepted in the fire cycle and the next state follows the accepted command's kind. Fire with no accept→IDLE.
  - An illegal command accepted in the fire cycle→IDLE with illegal_err set.
- BARRIER: all_idle=1→IDLE. in_ready=0 while in this state.
- DRAIN: all_idle=1→STOP with halt_pulse=1. in_ready=0.
- Valid stability: once eng_cmd_valid[id] rises it stays high until fire. can_issue only falls after an issue, so this holds.
- Payload stability: eng_cmd_payload holds the registered payload and is stable throughout DISPATCH.
- Same-engine back-to-back: the scoreboard sets the busy bit one cycle after issue. The next command to the same engine therefore sees can_issue=0 in its first DISPATCH cycle and waits for engine done.
- Barrier immediately after an issue: the BARRIER state is entered one cycle after fire. all_idle already reflects the issued engine in that cycle, so the barrier cannot pass early.
- Reset mid-operation: everything returns to reset values, the held command is discarded, and counters clear.

## Timing
- Reset values:
  - state=STOP, in_ready=0, issue_valid=0, eng_cmd_valid=0, eng_cmd_payload=0.
  - running=0, halt_pulse=0, illegal_err=0, counters=0.
  - issue_engine_id=0.
- Accept→earliest fire: 1 cycle (accept cycle t, DISPATCH at t+1, fire at t+1 if free and ready).
- Throughput: one ENGINE command per cycle to distinct free engines.
- issue_valid and eng_cmd_valid are combinational from registered state plus can_issue/eng_cmd_ready. There is no combinational path from in_valid.
- BARRIER/DRAIN exit on the first cycle all_idle=1; that state's exit is visible on the next edge.
- stall_count increments each cycle in DISPATCH without fire, and each cycle in BARRIER with all_idle=0.
- Counters wrap at 2^32.

## Configuration
- NPU_ISSUE_PERF_EN defined: issue_count and stall_count are implemented as described.
- NPU_ISSUE_PERF_EN undefined: issue_count and stall_count are tied to 0 and no counter flops are built; all other behaviour is identical.

## Test plan
- Reset, start, then ENGINE id=2 payload=0xA5 with all engines free and ready: fire one cycle after accept, issue_valid=1, issue_engine_id=2, eng_cmd_valid=6'b000100, payload 0xA5.
- Two ENGINE commands to id=1 back-to-back, engine done after 10 cycles: second command fires exactly the cycle after can_issue[1] returns to 1; stall_count=10 (perf build).
- ENGINE id=0 then ENGINE id=3, both free: fires in consecutive cycles; issue_count=2.
- ENGINE id=4 then BARRIER, engine 4 done after 5 cycles: in_ready=0 until all_idle=1; the next command is accepted the cycle after.
- ENGINE with id=7 (NUM_ENGINES=6), then in_kind=3: both dropped, illegal_err=1 and stays 1, no issue_valid, state stays IDLE.
- END with engine 5 busy for 8 cycles: running stays 1, halt_pulse for exactly one cycle after all_idle, then running=0. A following start returns to IDLE.
